// File: rtl/clock_divider_multi_pkg.sv
// Shared types and constants for the multi-channel clock divider.
package clkdiv_pkg;

  localparam int unsigned DIV_W_DEFAULT = 8;
  localparam int unsigned DIV_STOP_MAX  = 1;

  typedef logic [DIV_W_DEFAULT-1:0] div_t;

  // Channel-select width, never narrower than one bit.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clock_divider_multi_if.sv
// Divisor configuration port: valid/ready write of one channel's divisor.
interface clock_divider_multi_if
  import clkdiv_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned DIV_W = DIV_W_DEFAULT
);

  localparam int unsigned CH_W = ch_width(N_CH);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_div,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_div,
    output cfg_ready
  );

endinterface

// File: rtl/clk_div_channel.sv
// One divider channel: counter, active/pending divisor and registered clk_out/tick.
module clk_div_channel
  import clkdiv_pkg::*;
#(
  parameter int unsigned DIV_W       = DIV_W_DEFAULT,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             align,
  input  logic             wr_en,
  input  logic [DIV_W-1:0] wr_div,
  output logic             pend_vld,
  output logic             clk_out,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             running, running_d, wrap;

  always_comb begin
    running    = div_q > DIV_W'(DIV_STOP_MAX);
    // A stopped channel wraps every edge so a pending divisor loads on the next one.
    wrap       = !running || align || (cnt_q == div_q - DIV_W'(1));
    div_d      = (wrap && pend_vld_q) ? pend_div_q : div_q;
    cnt_d      = wrap ? '0 : cnt_q + DIV_W'(1);
    pend_div_d = wr_en ? wr_div : pend_div_q;
    pend_vld_d = pend_vld_q;
    if (wrap) begin
      pend_vld_d = 1'b0;
    end
    if (wr_en) begin
      pend_vld_d = 1'b1;
    end
    running_d  = div_d > DIV_W'(DIV_STOP_MAX);
    clk_out_d  = running_d && (cnt_d < (div_d >> 1));
    tick_d     = running_d && wrap;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt_q      <= DIV_W'(DEFAULT_DIV - 1);
      div_q      <= DIV_W'(DEFAULT_DIV);
      pend_div_q <= '0;
      pend_vld_q <= 1'b0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_div_q <= pend_div_d;
      pend_vld_q <= pend_vld_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
    end
  end

  assign pend_vld = pend_vld_q;
  assign clk_out  = clk_out_q;
  assign tick     = tick_q;

endmodule

// File: rtl/clock_divider_multi.sv
// N independent run-time programmable clock dividers with a shared config port and align.
module clock_divider_multi
  import clkdiv_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned DIV_W       = DIV_W_DEFAULT,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic                align,
  clock_divider_multi_if.slave cfg,
  output logic [N_CH-1:0]     clk_out,
  output logic [N_CH-1:0]     tick
);

  localparam int unsigned CH_W = ch_width(N_CH);

  logic [N_CH-1:0] pend_vld;
  logic [N_CH-1:0] wr_en;
  logic            xfer;

  // Out-of-range channels keep the default ready so the write is swallowed.
  always_comb begin
    cfg.cfg_ready = 1'b1;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (cfg.cfg_ch == CH_W'(i)) begin
        cfg.cfg_ready = !pend_vld[i];
      end
    end
  end

  assign xfer = cfg.cfg_valid && cfg.cfg_ready;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign wr_en[i] = xfer && (cfg.cfg_ch == CH_W'(i));

    clk_div_channel #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_in   (clk_in),
      .reset    (reset),
      .align    (align),
      .wr_en    (wr_en[i]),
      .wr_div   (cfg.cfg_div),
      .pend_vld (pend_vld[i]),
      .clk_out  (clk_out[i]),
      .tick     (tick[i])
    );
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed bench for clock_divider_multi with hand-computed clk_out/tick vectors.
module tb_clock_divider_multi;
  import clkdiv_pkg::*;

  logic       clk_in = 1'b0;
  logic       reset  = 1'b0;
  logic       align  = 1'b0;
  logic [3:0] clk_out;
  logic [3:0] tick;

  int n_cmp = 0;
  int n_err = 0;

  clock_divider_multi_if #(.N_CH(4), .DIV_W(8)) cfg_if ();

  clock_divider_multi #(
    .N_CH        (4),
    .DIV_W       (8),
    .DEFAULT_DIV (2)
  ) dut (
    .clk_in  (clk_in),
    .reset   (reset),
    .align   (align),
    .cfg     (cfg_if),
    .clk_out (clk_out),
    .tick    (tick)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic edge_chk(input string tag, input logic [3:0] ec, input logic [3:0] et);
    @(posedge clk_in);
    #1;
    chk({tag, "_clk"}, {4'h0, clk_out}, {4'h0, ec});
    chk({tag, "_tick"}, {4'h0, tick}, {4'h0, et});
  endtask

  task automatic ready_chk(input string tag, input logic exp);
    #1;
    chk(tag, {7'h0, cfg_if.cfg_ready}, {7'h0, exp});
  endtask

  task automatic cfg_set(input logic v, input logic [1:0] ch, input div_t d);
    cfg_if.cfg_valid = v;
    cfg_if.cfg_ch    = ch;
    cfg_if.cfg_div   = d;
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    reset = 1'b1;
    #1;
    chk("rst_hold_clk", {4'h0, clk_out}, 8'h00);
    @(negedge clk_in);
  endtask

  initial begin
    cfg_set(1'b0, 2'd1, 8'd0);
    #1 reset = 1'b1;
    #1;
    chk("rst_clk", {4'h0, clk_out}, 8'h00);
    chk("rst_tick", {4'h0, tick}, 8'h00);
    ready_chk("rst_ready", 1'b1);
    @(negedge clk_in);
    reset = 1'b0;

    // Reset release at the default divisor of 2
    edge_chk("a1", 4'hF, 4'hF);
    edge_chk("a2", 4'h0, 4'h0);
    edge_chk("a3", 4'hF, 4'hF);
    edge_chk("a4", 4'h0, 4'h0);

    // ch1 <- 5, accepted on a wrap edge, applies one period of 2 later
    cfg_set(1'b1, 2'd1, 8'd5);
    ready_chk("b_ready_pre", 1'b1);
    edge_chk("b5", 4'hF, 4'hF);
    cfg_if.cfg_valid = 1'b0;
    ready_chk("b_ready_busy", 1'b0);
    edge_chk("b6", 4'h0, 4'h0);
    edge_chk("b7", 4'hF, 4'hF);
    ready_chk("b_ready_free", 1'b1);
    edge_chk("b8", 4'h2, 4'h0);
    edge_chk("b9", 4'hD, 4'hD);
    edge_chk("b10", 4'h0, 4'h0);
    edge_chk("b11", 4'hD, 4'hD);
    edge_chk("b12", 4'h2, 4'h2);
    edge_chk("b13", 4'hF, 4'hD);

    // ch2 back-to-back writes 6 then 3
    do_reset();
    cfg_set(1'b1, 2'd2, 8'd6);
    reset = 1'b0;
    edge_chk("c1", 4'hF, 4'hF);
    cfg_if.cfg_div = 8'd3;
    ready_chk("c1_ready", 1'b0);
    edge_chk("c2", 4'h0, 4'h0);
    ready_chk("c2_ready", 1'b0);
    edge_chk("c3", 4'hF, 4'hF);
    ready_chk("c3_ready", 1'b1);
    edge_chk("c4", 4'h4, 4'h0);
    cfg_if.cfg_valid = 1'b0;
    ready_chk("c4_ready", 1'b0);
    edge_chk("c5", 4'hF, 4'hB);
    edge_chk("c6", 4'h0, 4'h0);
    edge_chk("c7", 4'hB, 4'hB);
    edge_chk("c8", 4'h0, 4'h0);
    edge_chk("c9", 4'hF, 4'hF);
    ready_chk("c9_ready", 1'b1);
    edge_chk("c10", 4'h0, 4'h0);
    edge_chk("c11", 4'hB, 4'hB);
    edge_chk("c12", 4'h4, 4'h4);
    edge_chk("c13", 4'hB, 4'hB);

    // ch0 stopped with 0, then restarted with 4
    do_reset();
    cfg_set(1'b1, 2'd0, 8'd0);
    reset = 1'b0;
    edge_chk("d1", 4'hF, 4'hF);
    cfg_if.cfg_valid = 1'b0;
    edge_chk("d2", 4'h0, 4'h0);
    edge_chk("d3", 4'hE, 4'hE);
    edge_chk("d4", 4'h0, 4'h0);
    edge_chk("d5", 4'hE, 4'hE);
    cfg_set(1'b1, 2'd0, 8'd4);
    ready_chk("d5_ready", 1'b1);
    edge_chk("d6", 4'h0, 4'h0);
    cfg_if.cfg_valid = 1'b0;
    edge_chk("d7", 4'hF, 4'hF);
    edge_chk("d8", 4'h1, 4'h0);
    edge_chk("d9", 4'hE, 4'hE);
    edge_chk("d10", 4'h0, 4'h0);
    edge_chk("d11", 4'hF, 4'hF);

    // Divisors 3/4/7 on ch0..2 (ch3 stays 2), then align
    do_reset();
    cfg_set(1'b1, 2'd0, 8'd3);
    reset = 1'b0;
    edge_chk("e1", 4'hF, 4'hF);
    cfg_set(1'b1, 2'd1, 8'd4);
    edge_chk("e2", 4'h0, 4'h0);
    cfg_set(1'b1, 2'd2, 8'd7);
    edge_chk("e3", 4'hF, 4'hF);
    cfg_if.cfg_valid = 1'b0;
    edge_chk("e4", 4'h2, 4'h0);
    edge_chk("e5", 4'hC, 4'hC);
    edge_chk("e6", 4'h5, 4'h1);
    align = 1'b1;
    edge_chk("e7_align", 4'hF, 4'hF);
    align = 1'b0;
    edge_chk("k1", 4'h6, 4'h0);
    edge_chk("k2", 4'hC, 4'h8);
    edge_chk("k3", 4'h1, 4'h1);
    edge_chk("k4", 4'hA, 4'hA);
    edge_chk("k5", 4'h2, 4'h0);
    edge_chk("k6", 4'h9, 4'h9);
    edge_chk("k7", 4'h4, 4'h4);
    edge_chk("k8", 4'hE, 4'hA);

    // Pending write to ch1 lost across a mid-period reset
    cfg_set(1'b1, 2'd1, 8'd9);
    edge_chk("k9", 4'h7, 4'h1);
    cfg_if.cfg_valid = 1'b0;
    ready_chk("f_ready_pend", 1'b0);
    #1 reset = 1'b1;
    #1;
    chk("f_async_clk", {4'h0, clk_out}, 8'h00);
    chk("f_async_tick", {4'h0, tick}, 8'h00);
    ready_chk("f_ready_clr", 1'b1);
    @(negedge clk_in);
    reset = 1'b0;
    edge_chk("f1", 4'hF, 4'hF);
    edge_chk("f2", 4'h0, 4'h0);
    edge_chk("f3", 4'hF, 4'hF);
    edge_chk("f4", 4'h0, 4'h0);
    edge_chk("f5", 4'hF, 4'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
